// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, state and instruction-field definitions for the hardwired control sequencer.
package cpu_ctrl_pkg;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHL  = 5'b01000;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NOP  = 5'b11001;
  localparam logic [4:0] OPC_HALT = 5'b11010;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_NOP     = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } opclass_e;

  // Register fields follow the opcode from the MSB downwards: Ra, Rb, Rc.
  function automatic int ra_lsb(input int data_w, input int opc_w, input int rw);
    return data_w - opc_w - rw;
  endfunction

  function automatic int rb_lsb(input int data_w, input int opc_w, input int rw);
    return data_w - opc_w - 2 * rw;
  endfunction

  function automatic int rc_lsb(input int data_w, input int opc_w, input int rw);
    return data_w - opc_w - 3 * rw;
  endfunction

  function automatic opclass_e classify(input logic [4:0] opc);
    opclass_e cls;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHL: cls = CLS_ALU;
      OPC_MUL, OPC_DIV: cls = CLS_MULDIV;
      OPC_NOP:          cls = CLS_NOP;
      OPC_HALT:         cls = CLS_HALT;
      default:          cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register-index to one-hot select decoder; output is all-zero when disabled.
module reg_select_decoder #(
  parameter int NUM_REGS = 16,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic [RW-1:0]       idx_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] sel_o
);

  // One-hot decode of the selected register.
  always_comb begin
    sel_o = '0;
    if (en_i) begin
      sel_o[idx_i] = 1'b1;
    end else begin
      sel_o = '0;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit: steps the datapath through T0..T6 and decodes IR
// into one-hot register selects, ALU opcode and bus/load strobes.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir,
  output logic                PCout,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                HIout,
  output logic                LOout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OPC_W-1:0]    alu_op,
  output logic                halted,
  output logic                illegal_op,
  output logic [3:0]          step
);

  localparam int RW     = $clog2(NUM_REGS);
  localparam int RA_LSB = ra_lsb(DATA_W, OPC_W, RW);
  localparam int RB_LSB = rb_lsb(DATA_W, OPC_W, RW);
  localparam int RC_LSB = rc_lsb(DATA_W, OPC_W, RW);

  state_e           state_q, state_d, eoi_s;
  opclass_e         cls_s;
  logic [OPC_W-1:0] opc_s;
  logic [RW-1:0]    ra_s, rb_s, rc_s, rout_idx_s;
  logic             rin_en_s, rout_en_s;
  logic             unused_ir_s;

  assign opc_s       = ir[DATA_W-1 -: OPC_W];
  assign ra_s        = ir[RA_LSB +: RW];
  assign rb_s        = ir[RB_LSB +: RW];
  assign rc_s        = ir[RC_LSB +: RW];
  assign unused_ir_s = ^ir[RC_LSB-1:0];
  assign cls_s       = classify(5'(opc_s));
  assign eoi_s       = run ? ST_T0 : ST_IDLE;
  assign step        = state_q;

  // State register; clear forces IDLE without waiting for a clock edge.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore strobe decode.
  always_comb begin
    state_d    = state_q;
    PCout      = 1'b0;
    Zhighout   = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    HIout      = 1'b0;
    LOout      = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    alu_op     = '0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    rin_en_s   = 1'b0;
    rout_en_s  = 1'b0;
    rout_idx_s = rb_s;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_T0;
        else     state_d = ST_IDLE;
      end
      ST_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        // PC is loaded only on the cycle memory answers, so waits never double-load it.
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) begin
          PCin    = 1'b1;
          state_d = ST_T2;
        end else begin
          state_d = ST_T1;
        end
      end
      ST_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        case (cls_s)
          CLS_ALU, CLS_MULDIV: begin
            rout_en_s  = 1'b1;
            rout_idx_s = rb_s;
            Yin        = 1'b1;
            state_d    = ST_T4;
          end
          CLS_NOP:  state_d = eoi_s;
          CLS_HALT: state_d = ST_HALT;
          default: begin
            illegal_op = 1'b1;
            state_d    = eoi_s;
          end
        endcase
      end
      ST_T4: begin
        rout_en_s  = 1'b1;
        rout_idx_s = rc_s;
        Zin        = 1'b1;
        alu_op     = opc_s;
        state_d    = ST_T5;
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (cls_s == CLS_MULDIV) begin
          LOin    = 1'b1;
          state_d = ST_T6;
        end else begin
          rin_en_s = 1'b1;
          state_d  = eoi_s;
        end
      end
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        state_d  = eoi_s;
      end
      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .idx_i (ra_s),
    .en_i  (rin_en_s),
    .sel_o (Rin)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .idx_i (rout_idx_s),
    .en_i  (rout_en_s),
    .sel_o (Rout)
  );

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the datapath through fetch and execute timing steps, so no external stimulus has to toggle individual strobes. It decodes the IR contents into one-hot register-select strobes and an ALU opcode. It generalises the fixed T0–T5 sequence to a parametrised register file, memory-wait handshaking, HI/LO multi-step ops, halt, and illegal-opcode handling. It sits beside `datapath` and connects strobe-for-strobe to its control ports.

## Interface
- `DATA_W`, 32: instruction/IR width.
- `NUM_REGS`, 16: register-file size. Must be a power of two. `RW = log2(NUM_REGS)` is the register-field width.
- `OPC_W`, 5: opcode width.
- `Clock` in 1: single clock. All state changes on the rising edge.
- `clear` in 1: reset, asynchronous, active-high.
- `run` in 1: allows leaving IDLE and starting the next instruction.
- `mem_ready` in 1: memory read data valid this cycle.
- `ir` in DATA_W: IR register output from the datapath.
- `PCout`, `Zhighout`, `Zlowout`, `MDRout`, `HIout`, `LOout` out 1: bus-drive strobes.
- `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin`, `HIin`, `LOin`, `IncPC`, `Read` out 1: load/control strobes.
- `Rin`, `Rout` out NUM_REGS: one-hot register load/drive selects.
- `alu_op` out OPC_W: ALU operation code.
- `halted` out 1: high in HALT.
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.
- `step` out 4: current state encoding, for debug.

## Operation
- Instruction fields:
  - opcode = `ir[DATA_W-1 -: OPC_W]`
  - Ra = next RW bits
  - Rb = next RW bits
  - Rc = next RW bits
  - For DATA_W=32 and NUM_REGS=16: [31:27], [26:23], [22:19], [18:15].
- Opcodes:
  - add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000
  - mul 01111, div 10000
  - nop 11001, halt 11010
  - All others are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- Outputs are Moore. Each is a combinational function of the state register and `ir`. Any strobe not listed for a state is 0.
  - IDLE: no strobes. Go to T0 when `run`=1.
  - T0: PCout, MARin, IncPC, Zin. Go to T1.
  - T1: Zlowout, PCin, Read, MDRin. Stay in T1 while `mem_ready`=0. Go to T2 on `mem_ready`=1. PCin is asserted only in the cycle in which `mem_ready`=1, so PC loads exactly once.
  - T2: MDRout, IRin. Go to T3.
  - T3, by opcode:
    - ALU ops and mul/div: `Rout[Rb]`, Yin. Go to T4.
    - nop: no strobes. Go to the end-of-instruction target.
    - halt: no strobes. Go to HALT.
    - illegal: `illegal_op`=1. Go to the end-of-instruction target.
  - T4: `Rout[Rc]`, Zin, `alu_op` = opcode. Go to T5.
  - T5:
    - ALU ops: Zlowout, `Rin[Ra]`. Go to the end-of-instruction target.
    - mul/div: Zlowout, LOin. Go to T6.
  - T6 (mul/div only): Zhighout, HIin. Go to the end-of-instruction target.
  - End-of-instruction target: T0 if `run`=1, else IDLE.
  - HALT: `halted`=1, no strobes. Left only by `clear`.
- `alu_op` is 0 in every state except T4.
- `Rin` and `Rout` are exactly one-hot when active, else all-zero.

## Timing
- Reset (`clear`=1, any state, including mid-instruction): state goes to IDLE immediately. All outputs are 0, with no wait for a clock edge. Operation resumes on the first rising edge after `clear` falls, provided `run`=1.
- Cycle counts with `mem_ready` held at 1, measured from T0 entry:
  - ALU op: 6 cycles.
  - mul/div: 7 cycles.
  - nop/illegal: 4 cycles.
  - halt: HALT is entered after 4 cycles.
- Each memory-wait cycle in T1 adds one cycle.
- `ir` must be stable from the end of T2 until the end of the instruction. The datapath loads IR at the T2→T3 edge.
- `run` is sampled only in IDLE and at the end of each instruction. Deasserting it mid-instruction never truncates that instruction.
- Simultaneous `clear` and any other input: `clear` wins.
- `illegal_op` and `halted` reset to 0.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - opcode localparams;
  - the state enum and its encoding (IDLE=0, T0..T6=1..7, HALT=8);
  - the field-offset functions of DATA_W/OPC_W/RW.
- Sub-module `reg_select_decoder`:
  - parameter NUM_REGS;
  - RW-bit index plus enable in, one-hot out;
  - instantiated twice: once for `Rin` (Ra), once for `Rout` (Rb in T3, Rc in T4).

## Test plan
- `and R1,R2,R3`, `ir`=0x28918000, run=1, mem_ready=1 -> T3 `Rout`=0x0004 with Yin; T4 `Rout`=0x0008, `alu_op`=00101, Zin; T5 `Rin`=0x0002 with Zlowout; back in T0 after 6 cycles.
- Same instruction with `mem_ready` low for 3 cycles in T1 -> Read/MDRin high for 4 cycles, PCin high only in the 4th; total 9 cycles.
- `mul R2,R3`, `ir`=0x78118000 -> T5 Zlowout+LOin, T6 Zhighout+HIin, `Rin` never nonzero; 7 cycles.
- `ir`=0xF8000000 -> `illegal_op` pulses exactly 1 cycle in T3, no Yin/Zin; then T0. `ir`=0xD0000000 -> HALT, `halted`=1, stays in HALT for 20 cycles despite `run`=1.
- Assert `clear` mid-T4 between edges -> all strobes 0 at once; `step`=IDLE; after release with run=1, T0 on the next edge.
- run=0 during T4 -> instruction completes through T5, then IDLE; reassert run -> T0 on the next edge.
